// File: rtl/nibble_seq_multiplier_pkg.sv
// Shared types and constants for the radix-16 sequential multiplier.
// The FSM states and the digit width live here.
package nibble_seq_multiplier_pkg;

   localparam int unsigned DIGIT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } state_e;

endpackage

// File: rtl/nibble_seq_multiplier_if.sv
// Request/response bundle between the ID/EX operand latch and the multiplier.
// The CPU side is the master and the multiplier is the slave.
interface nibble_seq_multiplier_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, is_signed, op_a, op_b,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, is_signed, op_a, op_b,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/nibble_pp_gen.sv
// Combinational partial-product generator: multiplicand times one 4-bit digit.
// The WIDTH+4 bit result is exact for every digit value.
module nibble_pp_gen
   import nibble_seq_multiplier_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0]         mcand,
   input  logic [DIGIT_W-1:0]       digit,
   output logic [WIDTH+DIGIT_W-1:0] pp
);
   assign pp = {{DIGIT_W{1'b0}}, mcand} * {{WIDTH{1'b0}}, digit};
endmodule

// File: rtl/nibble_seq_multiplier.sv
// Sequential radix-16 multiplier producing HI/LO for MULT/MULTU.
// One multiplier digit per cycle, then a sign-fix step that writes hi/lo and pulses done.
module nibble_seq_multiplier
   import nibble_seq_multiplier_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input logic                    clk,
   input logic                    rst_n,
   nibble_seq_multiplier_if.slave bus
);
   localparam int unsigned NDIG  = WIDTH / DIGIT_W;
   localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int unsigned P_W   = 2 * WIDTH;
   localparam int unsigned ACC_W = P_W + DIGIT_W;

   state_e                   state_q, state_d;
   logic [WIDTH-1:0]         mcand_q, mplr_q;
   logic                     neg_q;
   logic [P_W-1:0]           acc_q, acc_d, prod;
   logic [CNT_W-1:0]         cnt_q;
   logic [WIDTH-1:0]         hi_q, lo_q;
   logic                     done_q;
   logic [WIDTH+DIGIT_W-1:0] pp;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
      return (sgn && v[WIDTH-1]) ? -v : v;
   endfunction

   nibble_pp_gen #(.WIDTH(WIDTH)) u_pp_gen (
      .mcand (mcand_q),
      .digit (mplr_q[DIGIT_W-1:0]),
      .pp    (pp)
   );

   // Summed in a 2*WIDTH+4 bit datapath; the running partial product always fits back into 2*WIDTH.
   assign acc_d = P_W'((ACC_W'(acc_q) >> DIGIT_W) + (ACC_W'(pp) << (WIDTH - DIGIT_W)));
   assign prod  = neg_q ? -acc_q : acc_q;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (bus.start) state_d = ST_CALC;
         ST_CALC: if (cnt_q == CNT_W'(NDIG - 1)) state_d = ST_FIX;
         ST_FIX:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q <= '0;
         mplr_q  <= '0;
         neg_q   <= 1'b0;
         acc_q   <= '0;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  mcand_q <= magnitude(bus.op_a, bus.is_signed);
                  mplr_q  <= magnitude(bus.op_b, bus.is_signed);
                  neg_q   <= bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
                  acc_q   <= '0;
                  cnt_q   <= '0;
               end
            end
            ST_CALC: begin
               acc_q  <= acc_d;
               mplr_q <= mplr_q >> DIGIT_W;
               cnt_q  <= cnt_q + CNT_W'(1);
            end
            ST_FIX: begin
               {hi_q, lo_q} <= prod;
               done_q       <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = (state_q != ST_IDLE);
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
endmodule

// File: tb/tb_nibble_seq_multiplier.sv
// Scoreboard bench for nibble_seq_multiplier: expected products are queued at start
// and compared, together with their arrival cycle, when done pulses.
module tb_nibble_seq_multiplier;
   localparam int unsigned W = 32;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      int           cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb[$];
   logic [W-1:0] last_hi = '0;
   logic [W-1:0] last_lo = '0;

   nibble_seq_multiplier_if #(.WIDTH(W)) bus ();

   nibble_seq_multiplier #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
      logic signed [63:0] sa, sbv;
      if (sgn) begin
         sa  = {{W{a[W-1]}}, a};
         sbv = {{W{b[W-1]}}, b};
         return sa * sbv;
      end
      return {{W{1'b0}}, a} * {{W{1'b0}}, b};
   endfunction

   // Drives a one-cycle start; caller guarantees the DUT is idle in the next edge.
   task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      logic [63:0] p;
      p = model(sgn, a, b);
      e.hi = p[63:32];
      e.lo = p[31:0];
      e.cyc = cyc + 10;
      sb.push_back(e);
      bus.start = 1'b1;
      bus.is_signed = sgn;
      bus.op_a = a;
      bus.op_b = b;
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 40; i++) begin
         if (sb.size() == 0) break;
         @(posedge clk);
      end
      check("drain_timeout", 64'(sb.size()), 64'd0);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.done) begin
         if (sb.size() == 0) begin
            check("spurious_done", 64'(bus.done), 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("hi", 64'(bus.hi), 64'(e.hi));
            check("lo", 64'(bus.lo), 64'(e.lo));
            check("done_cycle", 64'(cyc), 64'(e.cyc));
            last_hi <= e.hi;
            last_lo <= e.lo;
         end
      end
   end

   initial begin
      int busy_cnt;
      logic [W-1:0] ra, rb;
      bus.start = 1'b0;
      bus.is_signed = 1'b0;
      bus.op_a = '0;
      bus.op_b = '0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_hi", 64'(bus.hi), 64'd0);
      check("rst_lo", 64'(bus.lo), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Max unsigned operands; busy must span exactly the 9 working cycles.
      issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      busy_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.busy) busy_cnt++;
      end
      check("busy_cycles", 64'(busy_cnt), 64'd9);
      wait_idle();

      issue(1'b1, 32'hFFFF_FFFF, 32'h0000_0005); wait_idle();
      issue(1'b0, 32'hFFFF_FFFF, 32'h0000_0005); wait_idle();
      issue(1'b1, 32'h8000_0000, 32'h8000_0000); wait_idle();
      issue(1'b1, 32'h8000_0000, 32'h0000_0001); wait_idle();
      issue(1'b0, 32'h8000_0000, 32'h8000_0000); wait_idle();

      // Start and operand changes while busy must be ignored.
      issue(1'b0, 32'd7, 32'd6);
      bus.start = 1'b1;
      bus.op_a = 32'd3;
      bus.op_b = 32'd3;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (2) @(posedge clk);
      #1 bus.op_a = 32'hDEAD_BEEF;
      wait_idle();
      repeat (12) @(posedge clk);
      #1;

      // Asynchronous reset mid-operation cancels it.
      issue(1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (3) @(posedge clk);
      #2;
      sb.delete();
      rst_n = 1'b0;
      #1;
      check("arst_busy", 64'(bus.busy), 64'd0);
      check("arst_done", 64'(bus.done), 64'd0);
      check("arst_hi", 64'(bus.hi), 64'd0);
      check("arst_lo", 64'(bus.lo), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check("post_rst_idle", 64'(bus.busy), 64'd0);
      issue(1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
      wait_idle();

      // Back-to-back: next start issued in the done cycle.
      issue(1'b0, 32'd7, 32'd6);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.done) break;
      end
      check("b2b_done_seen", 64'(bus.done), 64'd1);
      issue(1'b0, 32'd3, 32'd3);
      wait_idle();

      // Random operands; hi/lo must hold the previous result while a new one is computed.
      for (int i = 0; i < 8; i++) begin
         ra = $urandom();
         rb = $urandom();
         issue(1'($urandom_range(1)), ra, rb);
         repeat (4) @(posedge clk);
         #1;
         check("hold_hi", 64'(bus.hi), 64'(last_hi));
         check("hold_lo", 64'(bus.lo), 64'(last_lo));
         wait_idle();
      end

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
